pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
Parametrised program-counter generator for the IF stage of the RISC-V pipeline, replacing the plain enable-gated PC register. Selects the next fetch address from the trap, EX-stage redirect, stall and sequential sources with fixed priority. Presents the PC to instruction fetch with a valid/ready handshake and detects misaligned redirect targets.

Parameters:
XLEN, 32, PC and address width in bits (32 or 64).
RESET_VECTOR, 0, PC value loaded on reset; must be IALIGN-aligned.
IALIGN, 32, instruction alignment in bits (32: low 2 bits must be 0; 16: low bit must be 0).
RAS_DEPTH, 4, return-address-stack entries (power of two, 2..16); used only with RAS_EN.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard-unit stall; holds the PC
fetch_ready  input  1  IF stage accepts the current PC this cycle
redirect_valid  input  1  EX-stage branch/jump resolved taken
redirect_target  input  XLEN  branch/jump target
trap_valid  input  1  trap or xRET request from CSR unit
trap_vector  input  XLEN  trap handler or return address
fetch_is_call  input  1  predecode: accepted instruction is a call (JAL/JALR with rd=x1/x5)
fetch_is_ret  input  1  predecode: accepted instruction is a return (JALR x0,0(x1/x5))
pc  output  XLEN  current fetch address
pc_valid  output  1  pc is a valid fetch request
flush  output  1  one-cycle pulse: younger IF/ID contents invalid
misalign_fault  output  1  one-cycle pulse: misaligned redirect target detected
fault_addr  output  XLEN  offending target, held until the next fault

Behaviour:
- Reset (async, active-high): pc=RESET_VECTOR, pc_valid=0, flush=0, misalign_fault=0, fault_addr=0, state=BOOT, RAS empty.
- State BOOT: exactly one cycle after reset deasserts, transition to RUN. pc_valid=1 from the first RUN cycle.
- State RUN, priority evaluated per cycle (highest first):
  1. trap_valid: pc<=trap_vector with the low alignment bits forced to 0; flush=1 next cycle; RAS cleared. Independent of stall and fetch_ready.
  2. redirect_valid with an aligned target: pc<=redirect_target; flush=1. Independent of stall and fetch_ready.
  3. redirect_valid with a misaligned target: pc holds; misalign_fault=1 and fault_addr<=redirect_target next cycle; flush=1; go to FAULT.
  4. stall=1 or fetch_ready=0: pc holds.
  5. Otherwise (fetch accepted): pc<=pc+IALIGN/8 (or the RAS prediction); result is modulo 2^XLEN, so the all-ones-aligned address wraps to 0.
- A fetch is accepted when pc_valid && fetch_ready && !stall.
- State FAULT: pc_valid=0; pc holds; redirect_valid and stall are ignored. trap_valid loads the forced-aligned vector and returns to RUN with pc_valid=1 in the next cycle.
- Registered outputs update one cycle after the deciding inputs. flush and misalign_fault are never asserted for two consecutive cycles unless re-triggered.
- trap_valid in BOOT: taken; the transition to RUN still occurs.
- Reset mid-operation: immediate return to reset values; any pending flush or fault pulse is dropped.

Optional Feature:
- Macro: PC_GEN_RAS_EN.
- Defined: a circular RAS of RAS_DEPTH XLEN-bit entries.
  - On an accepted fetch with fetch_is_call: push pc+IALIGN/8; next pc is sequential.
  - On an accepted fetch with fetch_is_ret and the RAS non-empty: next pc = top entry, then pop.
  - Ret with an empty RAS: sequential.
  - Push when full: overwrite the oldest entry; count saturates at RAS_DEPTH.
  - call and ret together: treated as ret.
  - A redirect does not modify the RAS; a trap clears it.
- Undefined: fetch_is_call and fetch_is_ret are ignored, RAS_DEPTH is unused, and no RAS storage is inferred.

Test Plan:
- Reset with RESET_VECTOR=0x100 -> pc=0x100, pc_valid=0 for one cycle after release, then 1; with fetch_ready=1, pc follows 0x104, 0x108.
- stall=1 for 3 cycles at pc=0x200 -> pc stays 0x200; redirect_valid with target 0x400 during stall -> pc=0x400 and flush=1 for exactly one cycle.
- Same cycle trap_valid (vector 0x8003) and redirect_valid (target 0x500) -> pc=0x8000, flush=1, redirect ignored.
- redirect_target=0x302 with IALIGN=32 -> misalign_fault=1 for one cycle, fault_addr=0x302, pc_valid=0 until trap_valid with vector 0x1000 -> pc=0x1000, pc_valid=1.
- XLEN=32, pc=0xFFFFFFFC, fetch accepted -> pc=0x00000000.
- PC_GEN_RAS_EN, RAS_DEPTH=2: calls at 0x10, 0x20, 0x30, then three rets -> next pcs 0x34, 0x24, then sequential (oldest entry overwritten, RAS empty).

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage: trap > redirect > stall > sequential fetch.
// Optional return-address stack is built only when PC_GEN_RAS_EN is defined.
//
// state | meaning
// BOOT  | first cycle after reset release, no fetch request
// RUN   | normal fetch, pc_valid asserted
// FAULT | misaligned redirect seen, fetch halted until a trap
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 32,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            fetch_is_call,
    input  logic            fetch_is_ret,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
    output logic            misalign_fault,
    output logic [XLEN-1:0] fault_addr
);

    localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);
    localparam logic [XLEN-1:0] PC_INC     = (IALIGN == 16) ? XLEN'(2) : XLEN'(4);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FAULT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;
    logic            flush_q, flush_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] next_fetch_pc;
    logic            fetch_go;

    assign seq_pc   = pc_q + PC_INC;
    assign fetch_go = (state_q == ST_RUN) && fetch_ready && !stall
                      && !trap_valid && !redirect_valid;

`ifdef PC_GEN_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW:0] RAS_FULL = (PW + 1)'(RAS_DEPTH);

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   sp_q;
    logic [PW:0]     cnt_q;
    logic [PW-1:0]   top_idx;
    logic            ras_pop;
    logic            ras_push;

    // sp_q points at the next free slot; when full that slot holds the oldest entry
    assign top_idx       = sp_q - 1'b1;
    assign ras_pop       = fetch_go && fetch_is_ret && (cnt_q != '0);
    assign ras_push      = fetch_go && fetch_is_call && !fetch_is_ret;
    assign next_fetch_pc = ras_pop ? ras_q[top_idx] : seq_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else if (trap_valid) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else if (ras_pop) begin
            sp_q  <= top_idx;
            cnt_q <= cnt_q - 1'b1;
        end else if (ras_push) begin
            sp_q <= sp_q + 1'b1;
            if (cnt_q != RAS_FULL) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_q[sp_q] <= seq_pc;
        end
    end
`else
    logic unused_ras;
    assign unused_ras    = ^{fetch_is_call, fetch_is_ret, RAS_DEPTH != 0};
    assign next_fetch_pc = seq_pc;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            fault_addr_q <= '0;
            flush_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fault_addr_q <= fault_addr_d;
            flush_q      <= flush_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_addr_d = fault_addr_q;
        flush_d      = 1'b0;
        fault_d      = 1'b0;
        // a trap wins in every state, including BOOT and FAULT
        if (trap_valid) begin
            pc_d    = trap_vector & ~ALIGN_MASK;
            flush_d = 1'b1;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN: begin
                    if (redirect_valid) begin
                        flush_d = 1'b1;
                        if ((redirect_target & ALIGN_MASK) != '0) begin
                            fault_d      = 1'b1;
                            fault_addr_d = redirect_target;
                            state_d      = ST_FAULT;
                        end else begin
                            pc_d = redirect_target;
                        end
                    end else if (fetch_go) begin
                        pc_d = next_fetch_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc             = pc_q;
    assign pc_valid       = (state_q == ST_RUN);
    assign flush          = flush_q;
    assign misalign_fault = fault_q;
    assign fault_addr     = fault_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: driver pushes model expectations, monitor pops and compares.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h100;
`ifdef PC_GEN_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, fetch_ready = 1'b0;
    logic        redirect_valid = 1'b0, trap_valid = 1'b0;
    logic [31:0] redirect_target = '0, trap_vector = '0;
    logic        fetch_is_call = 1'b0, fetch_is_ret = 1'b0;
    logic [31:0] pc, fault_addr;
    logic        pc_valid, flush, misalign_fault;

    pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(32), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .fetch_is_call(fetch_is_call), .fetch_is_ret(fetch_is_ret),
        .pc(pc), .pc_valid(pc_valid), .flush(flush),
        .misalign_fault(misalign_fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        fault;
        logic [31:0] faddr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // reference model: phase 0 = booting, 1 = running, 2 = faulted
    int          m_phase = 0;
    logic [31:0] m_pc = RV;
    logic [31:0] m_faddr = '0;
    logic [31:0] m_ras[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic rdy,
                        input logic rv, input logic [31:0] rt,
                        input logic tv, input logic [31:0] tvec,
                        input logic c, input logic r);
        exp_t e;
        logic m_flush, m_fault;
        @(negedge clk);
        reset = rst; stall = st; fetch_ready = rdy;
        redirect_valid = rv; redirect_target = rt;
        trap_valid = tv; trap_vector = tvec;
        fetch_is_call = c; fetch_is_ret = r;
        m_flush = 1'b0;
        m_fault = 1'b0;
        if (rst) begin
            m_phase = 0; m_pc = RV; m_faddr = '0; m_ras.delete();
        end else if (tv) begin
            m_pc = tvec & 32'hFFFF_FFFC;
            m_flush = 1'b1;
            m_phase = 1;
            m_ras.delete();
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (rv) begin
                m_flush = 1'b1;
                if (rt % 4 != 0) begin
                    m_fault = 1'b1; m_faddr = rt; m_phase = 2;
                end else begin
                    m_pc = rt;
                end
            end else if (rdy && !st) begin
                if (RAS_EN && r && m_ras.size() > 0) begin
                    m_pc = m_ras.pop_back();
                end else begin
                    if (RAS_EN && c && !r) begin
                        m_ras.push_back(m_pc + 32'd4);
                        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                    end
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        e.pc = m_pc; e.valid = (m_phase == 1); e.flush = m_flush;
        e.fault = m_fault; e.faddr = m_faddr;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, rdy, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic redirect(input logic [31:0] t);
        step(1'b0, 1'b0, 1'b1, 1'b1, t, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // monitor: one DUT output set per clock, compared after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", pc, e.pc);
                check("pc_valid", 32'(pc_valid), 32'(e.valid));
                check("flush", 32'(flush), 32'(e.flush));
                check("misalign_fault", 32'(misalign_fault), 32'(e.fault));
                check("fault_addr", fault_addr, e.faddr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] t, v;
        int k;
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) idle(1'b1);                       // BOOT, 0x100, 0x104
        idle(1'b1);                                  // 0x108
        redirect(32'h200);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h400, 1'b0, '0, 1'b0, 1'b0);
        idle(1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 32'h8003, 1'b0, 1'b0);
        idle(1'b0);
        redirect(32'h302);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h600, 1'b0, '0, 1'b0, 1'b0);
        idle(1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h1000, 1'b0, 1'b0);
        idle(1'b1);
        redirect(32'hFFFF_FFFC);
        idle(1'b1);                                  // wraps to 0
        idle(1'b0);
        redirect(32'h10);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        redirect(32'h20);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        redirect(32'h30);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        redirect(32'h44);                            // fault then reset mid-pulse
        redirect(32'h47);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        idle(1'b1);
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 99);
            t = $urandom;
            v = $urandom;
            if ($urandom_range(0, 3) != 0) t = t & 32'hFFFF_FFFC;
            if (k < 2) begin
                step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
            end else begin
                step(1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
                     $urandom_range(0, 9) == 0, t, k < 7, v,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            end
        end
        idle(1'b0);
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
